// File: rtl/ifu_fetch_pkg.sv
// Shared types and defaults for the IFU fetch front end.
package ifu_fetch_pkg;

  // PC value the fetch unit starts from after reset.
  localparam logic [31:0] IFU_RESET_PC = 32'hBFC00000;

  // Field widths of a fetch-buffer entry.
  localparam int FE_PC_W   = 32;
  localparam int FE_INST_W = 32;
  localparam int FE_PTGT_W = 32;

  // Metadata captured when a request is accepted, replayed when its response returns.
  typedef struct packed {
    logic [FE_PC_W-1:0]   pc;
    logic                 pred_taken;
    logic [FE_PTGT_W-1:0] pred_target;
  } fetch_meta_t;

  // One fetched bundle as presented to ID.
  typedef struct packed {
    logic [FE_PC_W-1:0]   pc;
    logic [FE_INST_W-1:0] inst0;
    logic [FE_INST_W-1:0] inst1;
    logic                 inst1_valid;
    logic                 pred_taken;
    logic [FE_PTGT_W-1:0] pred_target;
  } fetch_entry_t;

  localparam int FM_W = $bits(fetch_meta_t);
  localparam int FE_W = $bits(fetch_entry_t);

  // Pair a 64-bit I-cache line with its request metadata. A PC in the upper
  // word of the line means only one instruction of the pair is usable.
  function automatic fetch_entry_t build_entry(input fetch_meta_t meta,
                                               input logic [63:0] data);
    fetch_entry_t e;
    e.pc          = meta.pc;
    e.inst0       = meta.pc[2] ? data[63:32] : data[31:0];
    e.inst1       = data[63:32];
    e.inst1_valid = ~meta.pc[2];
    e.pred_taken  = meta.pred_taken;
    e.pred_target = meta.pred_target;
    return e;
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Bus bundle between the fetch unit, the I-cache and the ID stage.
interface ifu_fetch_if;
  import ifu_fetch_pkg::*;

  // I-cache request/response
  logic        inst_req_valid;
  logic        inst_req_ready;
  logic [31:0] inst_req_addr;
  logic        inst_resp_valid;
  logic [63:0] inst_resp_data;

  // Fetch buffer head towards ID
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst0;
  logic [31:0] out_inst1;
  logic        out_inst1_valid;
  logic        out_pred_taken;
  logic [31:0] out_pred_target;

  // Fetch unit side
  modport master (
    output inst_req_valid, inst_req_addr,
    input  inst_req_ready, inst_resp_valid, inst_resp_data,
    output out_valid, out_pc, out_inst0, out_inst1, out_inst1_valid,
    output out_pred_taken, out_pred_target,
    input  out_ready
  );

  // I-cache / ID side
  modport slave (
    input  inst_req_valid, inst_req_addr,
    output inst_req_ready, inst_resp_valid, inst_resp_data,
    input  out_valid, out_pc, out_inst0, out_inst1, out_inst1_valid,
    input  out_pred_taken, out_pred_target,
    output out_ready
  );

endinterface

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; storage is not reset, only pointers and count.
module ifu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = pop && !empty;
  assign w_push = push && !full;
  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];

  // Storage write; contents beyond the read pointer are don't-care.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// IFU fetch front end: fetch PC register, credit-limited I-cache requests,
// in-order response pairing with prediction metadata and the ID fetch buffer.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = IFU_RESET_PC,
  parameter int          BUF_DEPTH       = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  input  logic        redirect,
  output logic [31:0] pc,
  ifu_fetch_if.master bus
);

  localparam int IW         = $clog2(MAX_OUTSTANDING) + 1;
  localparam int BW         = $clog2(BUF_DEPTH) + 1;
  // The metadata queue never holds more than the in-flight count.
  localparam int META_DEPTH = (MAX_OUTSTANDING < 2) ? 2 : MAX_OUTSTANDING;
  localparam int MW         = $clog2(META_DEPTH) + 1;

  logic [31:0]  r_pc;
  logic [IW-1:0] r_inflight;
  logic [IW-1:0] r_discard;

  logic [IW-1:0] w_inflight_nxt;
  logic [IW-1:0] w_discard_nxt;
  logic          w_credit;
  logic          w_req_valid;
  logic          w_accept;
  logic          w_resp_discard;
  logic          w_resp_keep;
  logic          w_resp_dec;
  logic          w_buf_push;
  logic          w_buf_pop;

  fetch_meta_t   w_meta_in;
  fetch_meta_t   w_meta_head;
  fetch_entry_t  w_entry;
  fetch_entry_t  w_buf_head;
  fetch_entry_t  w_head_out;

  logic          w_meta_full;
  logic          w_meta_empty;
  logic [MW-1:0] w_meta_count;
  logic          w_buf_full;
  logic          w_buf_empty;
  logic [BW-1:0] w_buf_count;
  logic          w_unused;

  // Credit: an accepted request always has a reserved buffer slot. The
  // metadata-full term is redundant with the in-flight limit but keeps the
  // queue safe by construction. Requests are held off during reset.
  assign w_credit    = (32'(r_inflight) + 32'(w_buf_count) < 32'(BUF_DEPTH)) &&
                       (32'(r_inflight) < 32'(MAX_OUTSTANDING)) && !w_meta_full;
  assign w_req_valid = rst && w_credit && !redirect;
  assign w_accept    = w_req_valid && bus.inst_req_ready;

  // Response classification: responses owed to a pre-redirect request are
  // discarded; responses with no metadata (stale after reset) are ignored.
  assign w_resp_discard = bus.inst_resp_valid && (r_discard != '0);
  assign w_resp_keep    = bus.inst_resp_valid && (r_discard == '0) && !w_meta_empty;
  assign w_resp_dec     = bus.inst_resp_valid && (r_inflight != '0);
  assign w_buf_push     = w_resp_keep && !redirect;
  assign w_buf_pop      = !w_buf_empty && bus.out_ready;

  assign w_inflight_nxt = r_inflight + IW'(w_accept) - IW'(w_resp_dec);

  assign w_meta_in = '{pc: r_pc, pred_taken: pred_taken, pred_target: pred_target};
  assign w_entry   = build_entry(w_meta_head, bus.inst_resp_data);

  // Responses still owed after a redirect become the discard count.
  always_comb begin
    w_discard_nxt = r_discard;
    if (redirect)            w_discard_nxt = w_inflight_nxt;
    else if (w_resp_discard) w_discard_nxt = r_discard - IW'(1);
  end

  // Fetch PC and request/discard counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
    end else begin
      if (redirect || w_accept) r_pc <= next_pc;
      r_inflight <= w_inflight_nxt;
      r_discard  <= w_discard_nxt;
    end
  end

  ifu_fifo #(
    .WIDTH (FM_W),
    .DEPTH (META_DEPTH)
  ) u_meta_q (
    .clk   (clk),
    .rst   (rst),
    .push  (w_accept),
    .pop   (w_resp_keep),
    .flush (redirect),
    .din   (w_meta_in),
    .dout  (w_meta_head),
    .full  (w_meta_full),
    .empty (w_meta_empty),
    .count (w_meta_count)
  );

  ifu_fifo #(
    .WIDTH (FE_W),
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (w_buf_push),
    .pop   (w_buf_pop),
    .flush (redirect),
    .din   (w_entry),
    .dout  (w_buf_head),
    .full  (w_buf_full),
    .empty (w_buf_empty),
    .count (w_buf_count)
  );

  // Head fields read zero whenever the buffer is empty, including in reset.
  assign w_head_out = w_buf_empty ? '0 : w_buf_head;

  assign pc                  = r_pc;
  assign bus.inst_req_valid  = w_req_valid;
  assign bus.inst_req_addr   = {r_pc[31:3], 3'b000};
  assign bus.out_valid       = !w_buf_empty;
  assign bus.out_pc          = w_head_out.pc;
  assign bus.out_inst0       = w_head_out.inst0;
  assign bus.out_inst1       = w_head_out.inst1;
  assign bus.out_inst1_valid = w_head_out.inst1_valid;
  assign bus.out_pred_taken  = w_head_out.pred_taken;
  assign bus.out_pred_target = w_head_out.pred_target;

  // Status outputs not needed by this block.
  assign w_unused = &{1'b0, w_meta_count, w_buf_full};

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  localparam int          BUF_DEPTH = 4;
  localparam int          MAX_OUT   = 2;
  localparam logic [31:0] RST_PC    = 32'hBFC00000;
  localparam int          NCYC      = 4000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] next_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        redirect;
  logic [31:0] pc;

  always #5 clk = ~clk;

  ifu_fetch_if bus ();

  ifu_fetch #(
    .RESET_PC        (RST_PC),
    .BUF_DEPTH       (BUF_DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .next_pc     (next_pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .redirect    (redirect),
    .pc          (pc),
    .bus         (bus)
  );

  // Reference model: queues of outstanding requests and buffered bundles.
  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
  } m_meta_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] i0;
    logic [31:0] i1;
    logic        v1;
    logic        pt;
    logic [31:0] tgt;
  } m_ent_t;

  m_meta_t     mq[$];
  m_ent_t      bq[$];
  int          m_inflight;
  int          m_discard;
  logic [31:0] m_pc;

  // I-cache behaviour: responses owed, and how many of those predate a reset.
  int ic_pend;
  int ic_stale;

  int checks;
  int errors;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic m_ent_t mk_ent(input m_meta_t m, input logic [63:0] d);
    m_ent_t e;
    e.pc  = m.pc;
    e.i0  = m.pc[2] ? d[63:32] : d[31:0];
    e.i1  = d[63:32];
    e.v1  = !m.pc[2];
    e.pt  = m.pt;
    e.tgt = m.tgt;
    return e;
  endfunction

  function automatic logic exp_req_valid();
    return rst && (m_inflight + bq.size() < BUF_DEPTH) &&
           (m_inflight < MAX_OUT) && !redirect;
  endfunction

  task automatic model_reset();
    mq.delete();
    bq.delete();
    m_inflight = 0;
    m_discard  = 0;
    m_pc       = RST_PC;
    ic_stale   = ic_pend;
  endtask

  task automatic check_outputs();
    m_ent_t h;
    chk("req_valid", bus.inst_req_valid, exp_req_valid());
    chk("pc", pc, m_pc);
    chk("req_addr", bus.inst_req_addr, {m_pc[31:3], 3'b000});
    chk("out_valid", bus.out_valid, bq.size() != 0);
    if (bq.size() != 0) h = bq[0];
    else h = '{pc: 0, i0: 0, i1: 0, v1: 0, pt: 0, tgt: 0};
    chk("out_pc", bus.out_pc, h.pc);
    chk("out_inst0", bus.out_inst0, h.i0);
    chk("out_inst1", bus.out_inst1, h.i1);
    chk("out_inst1_valid", bus.out_inst1_valid, h.v1);
    chk("out_pred_taken", bus.out_pred_taken, h.pt);
    chk("out_pred_target", bus.out_pred_target, h.tgt);
  endtask

  // Advance the model across one rising edge using the inputs of this cycle.
  task automatic model_step();
    logic    acc;
    m_meta_t m;
    if (!rst) return;
    acc = exp_req_valid() && bus.inst_req_ready;
    if (bq.size() != 0 && bus.out_ready) void'(bq.pop_front());
    if (bus.inst_resp_valid) begin
      if (m_discard > 0) begin
        m_discard--;
        m_inflight--;
      end else if (mq.size() != 0) begin
        m = mq.pop_front();
        m_inflight--;
        if (!redirect) bq.push_back(mk_ent(m, bus.inst_resp_data));
      end
      ic_pend--;
      if (ic_stale > 0) ic_stale--;
    end
    if (acc) begin
      mq.push_back('{pc: m_pc, pt: pred_taken, tgt: pred_target});
      m_inflight++;
      ic_pend++;
    end
    if (redirect) begin
      bq.delete();
      mq.delete();
      m_discard = m_inflight;
      m_pc      = next_pc;
    end else if (acc) begin
      m_pc = next_pc;
    end
  endtask

  // Random stimulus; ph selects a traffic profile so that full-buffer
  // back-pressure, bursty responses and frequent redirects all occur.
  task automatic drive_inputs(input int ph, input logic do_rst);
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] r2;
    int rdy_pct, rsp_pct, or_pct, rd_mod;
    case (ph)
      0:       begin rdy_pct = 90;  rsp_pct = 60;  or_pct = 70;  rd_mod = 24; end
      1:       begin rdy_pct = 100; rsp_pct = 80;  or_pct = 0;   rd_mod = 64; end
      2:       begin rdy_pct = 50;  rsp_pct = 40;  or_pct = 90;  rd_mod = 8;  end
      default: begin rdy_pct = 100; rsp_pct = 100; or_pct = 100; rd_mod = 16; end
    endcase
    r0 = $urandom;
    r1 = $urandom;
    r2 = $urandom;
    rst         = !do_rst;
    next_pc     = ($urandom_range(0, 3) == 0) ? {r0[31:2], 2'b00} : m_pc + 32'd8;
    pred_taken  = r1[0];
    pred_target = {r1[31:2], 2'b00};
    redirect    = ($urandom_range(0, rd_mod - 1) == 0);
    bus.inst_req_ready  = (ic_stale == 0) && ($urandom_range(0, 99) < rdy_pct);
    bus.inst_resp_valid = !do_rst && (ic_pend > 0) && ($urandom_range(0, 99) < rsp_pct);
    bus.inst_resp_data  = {r2, r0 ^ r1};
    bus.out_ready       = ($urandom_range(0, 99) < or_pct);
    if (do_rst) model_reset();
  endtask

  initial begin
    logic do_rst;
    checks   = 0;
    errors   = 0;
    ic_pend  = 0;
    ic_stale = 0;
    rst = 1'b0;
    next_pc = 32'h0;
    pred_taken = 1'b0;
    pred_target = 32'h0;
    redirect = 1'b0;
    bus.inst_req_ready  = 1'b0;
    bus.inst_resp_valid = 1'b0;
    bus.inst_resp_data  = 64'h0;
    bus.out_ready       = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_outputs();

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      do_rst = (cyc > 20) && ($urandom_range(0, 199) == 0);
      drive_inputs((cyc / 250) % 4, do_rst);
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_step();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- PC register and instruction-fetch front end of the IFU. Sits directly downstream of the next-PC logic.
- Holds the architectural fetch PC and feeds it back to the next-PC logic for prediction.
- Issues 8-byte-aligned fetch requests to the I-cache and pairs in-order responses with their PC and prediction metadata.
- Buffers fetched bundles for ID with a valid/ready handshake; discards in-flight responses on redirect.

Parameters:
- RESET_PC, 32'hBFC00000, PC value after reset.
- BUF_DEPTH, 4, fetch-buffer entries (power of two, ≥2).
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered I-cache requests (power of two, ≤ BUF_DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- next_pc  in  32  next PC chosen by the next-PC logic.
- pred_taken  in  1  prediction for the current pc.
- pred_target  in  32  predicted target for the current pc.
- redirect  in  1  flush_req or exception_pc_ena this cycle; next_pc is the redirect target.
- pc  out  32  current fetch PC.
- inst_req_valid  out  1  fetch request valid.
- inst_req_ready  in  1  I-cache accepts the request.
- inst_req_addr  out  32  {pc[31:3],3'b000}.
- inst_resp_valid  in  1  response data valid; responses return in order.
- inst_resp_data  in  64  two instructions; [31:0] is at addr, [63:32] is at addr+4.
- out_valid  out  1  fetch-buffer head valid.
- out_ready  in  1  ID consumes the head.
- out_pc  out  32  PC of the first valid slot.
- out_inst0  out  32  first instruction.
- out_inst1  out  32  second instruction.
- out_inst1_valid  out  1  0 when pc[2]=1.
- out_pred_taken  out  1  stored prediction.
- out_pred_target  out  32  stored prediction target.

Behaviour:
- Reset (asynchronous, rst low):
  - pc=RESET_PC.
  - Fetch buffer empty; metadata queue empty.
  - inflight=0, discard=0.
  - inst_req_valid=0, out_valid=0.
  - All out_* data outputs read 0.
  - Reset asserted mid-transaction abandons everything. Responses arriving after reset deasserts with no matching metadata entry are dropped.
- Credit rule:
  - inst_req_valid = (inflight + buf_count < BUF_DEPTH) && (inflight < MAX_OUTSTANDING) && !redirect.
  - Every accepted request therefore has guaranteed buffer space; the buffer never overflows.
- Request accept (inst_req_valid && inst_req_ready):
  - Push {pc, pred_taken, pred_target} into the metadata queue.
  - inflight+1.
  - pc <= next_pc.
- pc holds when no request is accepted and there is no redirect.
- Response (inst_resp_valid):
  - If discard>0: drop the data, discard-1, inflight-1, no metadata pop.
  - Otherwise: pop metadata, inflight-1, push a buffer entry.
  - Entry contents: inst0 = pc[2] ? data[63:32] : data[31:0]; inst1 = data[63:32]; inst1_valid = ~pc[2].
  - Response-to-out_valid latency is 1 cycle.
- Redirect:
  - pc <= next_pc unconditionally.
  - Fetch buffer and metadata queue are cleared next cycle.
  - discard <= inflight after this cycle's response decrement. Requests are blocked, so none are accepted in a redirect cycle.
  - A response arriving in the redirect cycle is dropped.
  - out_valid=0 from the following cycle.
  - A redirect in the same cycle as out_ready consumes the head normally; ID sees the handshake complete.
- Output:
  - Head of the buffer is registered; out_valid = !empty.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop on a full buffer cannot occur because of the credit rule. Push and pop in the same cycle keeps buf_count unchanged.
- Counter widths: inflight and discard are $clog2(MAX_OUTSTANDING)+1 bits; buf_count is $clog2(BUF_DEPTH)+1 bits. Pointers wrap modulo depth.
- PC arithmetic is owned by the next-PC logic; this block performs no addition.

Decomposition:
- Shared header ifu_def.v: RESET_PC default and fetch-entry field widths/offsets (FE_PC, FE_INST0, FE_INST1, FE_I1V, FE_PT, FE_PTGT).
- One sub-module, ifu_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports push, pop, flush, full, empty, count.
  - Instantiated twice: metadata queue and fetch buffer.

Test Plan:
- Reset release, inst_req_ready=1, next_pc=pc+8: inst_req_addr=BFC00000, then BFC00008. After responses D0/D1, out_pc=BFC00000 with out_inst1_valid=1.
- pc=0x80000004 accepted, response data=64'hAAAA_BBBB_CCCC_DDDD: out_inst0=AAAABBBB, out_inst1_valid=0, out_pc=80000004.
- out_ready=0, I-cache always ready: exactly 4 requests accepted, then inst_req_valid=0 with buf_count+inflight=4. One pop re-enables exactly one request.
- Two requests in flight, redirect with next_pc=0x80001000: pc=80001000 next cycle, out_valid=0. Both late responses are dropped (discard 2→0). The next request address is 80001000.
- pred_taken=1, pred_target=0x80002000 at request accept: the matching buffered entry carries out_pred_taken=1 and out_pred_target=80002000.
- rst low for 1 cycle with 1 request in flight: all outputs are at reset values asynchronously, and the stale response after release produces no out_valid.
